// File: rtl/mdio_frame_controller.sv
// MDIO (Clause 22) frame sequencer: serialises preamble, ST, OP, PHYAD, REGAD,
// TA and DATA one bit slot per MDC cycle and collects read payloads from the
// registered MDIO data controller.
// Optional build macro MDIO_TA_CHECK_EN: enables the read turnaround check
// that drives o_ta_err; without it o_ta_err is tied low.
module mdio_frame_controller #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        i_mdio_clk_mdc,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_r_data_bit,
  output logic        o_w_data_bit,
  output logic        o_mdio_io,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rd_data,
  output logic        o_ta_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_DONE
  } state_t;

  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wr_q, wr_d;
  logic [15:0] rd_shift_q, rd_shift_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        shift_en_q, shift_en_d;
  logic [15:0] rd_capture;
  logic        rd_commit;
  logic [2:0]  fld_idx;
  logic [3:0]  dat_idx;

  assign fld_idx    = 3'd4 - cnt_q[2:0];
  assign dat_idx    = 4'd15 - cnt_q[3:0];
  assign rd_capture = {rd_shift_q[14:0], i_r_data_bit};
  assign rd_commit  = (state_q == S_DONE) && rw_q;

  // Frame state register plus latched request fields and read shift path
  always_ff @(posedge i_mdio_clk_mdc or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      phy_q      <= '0;
      reg_q      <= '0;
      wr_q       <= '0;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      phy_q      <= phy_d;
      reg_q      <= reg_d;
      wr_q       <= wr_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      shift_en_q <= shift_en_d;
    end
  end

  // Next-state, slot counter and request latching; the read bit for a DATA
  // slot arrives one cycle late, so shifting follows a delayed enable
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 6'd1;
    rw_d       = rw_q;
    phy_d      = phy_q;
    reg_d      = reg_q;
    wr_d       = wr_q;
    shift_en_d = (state_q == S_DATA) && rw_q;
    rd_shift_d = shift_en_q ? rd_capture : rd_shift_q;
    rd_data_d  = rd_commit ? rd_capture : rd_data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_start) begin
          state_d = S_PRE;
          rw_d    = i_rw;
          phy_d   = i_phy_addr;
          reg_d   = i_reg_addr;
          wr_d    = i_wr_data;
        end
      end
      S_PRE:  if (cnt_q == PRE_LAST) begin state_d = S_ST;   cnt_d = '0; end
      S_ST:   if (cnt_q == 6'd1)     begin state_d = S_OP;   cnt_d = '0; end
      S_OP:   if (cnt_q == 6'd1)     begin state_d = S_PHY;  cnt_d = '0; end
      S_PHY:  if (cnt_q == 6'd4)     begin state_d = S_REG;  cnt_d = '0; end
      S_REG:  if (cnt_q == 6'd4)     begin state_d = S_TA;   cnt_d = '0; end
      S_TA:   if (cnt_q == 6'd1)     begin state_d = S_DATA; cnt_d = '0; end
      S_DATA: if (cnt_q == 6'd15)    begin state_d = S_DONE; cnt_d = '0; end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-slot line value and direction; read frames release the line from TA on
  always_comb begin
    o_w_data_bit = 1'b1;
    o_mdio_io    = 1'b1;
    case (state_q)
      S_PRE: o_mdio_io = 1'b0;
      S_ST: begin
        o_mdio_io    = 1'b0;
        o_w_data_bit = cnt_q[0];
      end
      S_OP: begin
        o_mdio_io    = 1'b0;
        o_w_data_bit = rw_q ? ~cnt_q[0] : cnt_q[0];
      end
      S_PHY: begin
        o_mdio_io    = 1'b0;
        o_w_data_bit = phy_q[fld_idx];
      end
      S_REG: begin
        o_mdio_io    = 1'b0;
        o_w_data_bit = reg_q[fld_idx];
      end
      S_TA: if (!rw_q) begin
        o_mdio_io    = 1'b0;
        o_w_data_bit = ~cnt_q[0];
      end
      S_DATA: if (!rw_q) begin
        o_mdio_io    = 1'b0;
        o_w_data_bit = wr_q[dat_idx];
      end
      default: ;
    endcase
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_rd_data = rd_commit ? rd_capture : rd_data_q;

`ifdef MDIO_TA_CHECK_EN
  logic ta_chk_q, ta_chk_d;
  logic ta_err_q, ta_err_d;

  // Turnaround check state: flag the delayed sample of the second TA slot
  always_ff @(posedge i_mdio_clk_mdc or posedge i_reset) begin
    if (i_reset) begin
      ta_chk_q <= 1'b0;
      ta_err_q <= 1'b0;
    end else begin
      ta_chk_q <= ta_chk_d;
      ta_err_q <= ta_err_d;
    end
  end

  // A PHY that fails to pull the second TA bit low marks the read as suspect
  always_comb begin
    ta_chk_d = (state_q == S_TA) && rw_q && (cnt_q == 6'd1);
    ta_err_d = ta_err_q;
    if ((state_q == S_IDLE) && i_start && i_rw) ta_err_d = 1'b0;
    if (ta_chk_q && i_r_data_bit) ta_err_d = 1'b1;
  end

  assign o_ta_err = ta_err_q;
`else
  assign o_ta_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_frame_controller.sv
// Directed self-checking bench for mdio_frame_controller (default 32-bit
// preamble instance plus a PREAMBLE_LEN=1 instance for back-to-back frames).
module tb_mdio_frame_controller;

`ifdef MDIO_TA_CHECK_EN
  localparam logic TA_BAD_EXP = 1'b1;
`else
  localparam logic TA_BAD_EXP = 1'b0;
`endif

  localparam logic [63:0] EXP_W1140 =
    {32'hFFFF_FFFF, 4'b0101, 5'b00001, 5'b00000, 2'b10, 16'b0001000101000000};
  localparam logic [45:0] EXP_R_HEAD =
    {32'hFFFF_FFFF, 4'b0110, 5'b11111, 5'b00010};
  localparam logic [63:0] EXP_R_IO = {46'h0, 18'h3FFFF};

  logic clk = 1'b0;
  logic rst, start0, start1, rw, rbit;
  logic [4:0] phy, regad;
  logic [15:0] wr;
  logic w0, io0, busy0, done0, ta0;
  logic [15:0] rd0;
  logic w1, io1, busy1, done1, ta1;
  logic [15:0] rd1;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdio_frame_controller dut0 (
    .i_mdio_clk_mdc(clk), .i_reset(rst), .i_start(start0), .i_rw(rw),
    .i_phy_addr(phy), .i_reg_addr(regad), .i_wr_data(wr), .i_r_data_bit(rbit),
    .o_w_data_bit(w0), .o_mdio_io(io0), .o_busy(busy0), .o_done(done0),
    .o_rd_data(rd0), .o_ta_err(ta0)
  );

  mdio_frame_controller #(.PREAMBLE_LEN(1)) dut1 (
    .i_mdio_clk_mdc(clk), .i_reset(rst), .i_start(start1), .i_rw(rw),
    .i_phy_addr(phy), .i_reg_addr(regad), .i_wr_data(wr), .i_r_data_bit(rbit),
    .o_w_data_bit(w1), .o_mdio_io(io1), .o_busy(busy1), .o_done(done1),
    .o_rd_data(rd1), .o_ta_err(ta1)
  );

  // Runs one frame on dut0 and records the observed slots; acceptance edge is
  // edge 0, slot s is visible after edge s, and the PHY model presents the
  // bit for slot s one cycle later, as the registered data controller would.
  task automatic do_frame(input logic f_rw, input logic [4:0] f_phy, input logic [4:0] f_reg,
                          input logic [15:0] f_wr, input logic [15:0] f_rdata, input logic f_ta,
                          output logic [63:0] bits, output logic [63:0] ios, output int done_n,
                          output logic [15:0] rd_at, output logic ta_at, output logic busy_s0,
                          output logic done_after, output logic busy_after,
                          output logic [15:0] rd_after);
    int n;
    int s;
    bits = '1; ios = '1; done_n = -1; rd_at = '0; ta_at = 1'b0;
    @(negedge clk);
    start0 = 1'b1; rw = f_rw; phy = f_phy; regad = f_reg; wr = f_wr; rbit = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; rw = ~f_rw; phy = ~f_phy; regad = ~f_reg; wr = ~f_wr;
    #1;
    bits[63] = w0; ios[63] = io0; busy_s0 = busy0;
    n = 0;
    while (done_n < 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
      s = n - 1;
      rbit = 1'b1;
      if (f_rw && s == 47) rbit = f_ta;
      if (f_rw && s >= 48 && s <= 63) rbit = f_rdata[63 - s];
      #1;
      if (n < 64) begin
        bits[63 - n] = w0;
        ios[63 - n]  = io0;
      end
      if (done0) begin
        done_n = n; rd_at = rd0; ta_at = ta0;
      end
    end
    @(posedge clk); #1;
    rbit = 1'b1;
    #1;
    done_after = done0; busy_after = busy0; rd_after = rd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; rw = 1'b0; rbit = 1'b1;
    phy = '0; regad = '0; wr = '0;
    #12;
    checks++; if (io0 !== 1'b1)   begin fails++; $display("[TB] FAIL reset_io: got %b expected 1", io0); end
    checks++; if (w0 !== 1'b1)    begin fails++; $display("[TB] FAIL reset_wbit: got %b expected 1", w0); end
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done0); end
    checks++; if (rd0 !== 16'h0000) begin fails++; $display("[TB] FAIL reset_rd: got %h expected 0000", rd0); end
    checks++; if (ta0 !== 1'b0)   begin fails++; $display("[TB] FAIL reset_ta: got %b expected 0", ta0); end
    checks++; if ({io1, w1, busy1, done1, ta1, rd1} !== {5'b11000, 16'h0000})
      begin fails++; $display("[TB] FAIL reset_dut1: got %b %b %b %b %b %h expected 1 1 0 0 0 0000",
                              io1, w1, busy1, done1, ta1, rd1); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [63:0] bits, ios; int dn; logic [15:0] rd_at, rd_after; logic ta_at, b0, da, ba;
    do_frame(1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, bits, ios, dn, rd_at, ta_at, b0, da, ba, rd_after);
    checks++; if (bits !== EXP_W1140) begin fails++; $display("[TB] FAIL write_bits: got %h expected %h", bits, EXP_W1140); end
    checks++; if (ios !== 64'h0) begin fails++; $display("[TB] FAIL write_io: got %h expected 0", ios); end
    // done in cycle 66 counting the request cycle as cycle 1 = 64 edges after acceptance
    checks++; if (dn != 64) begin fails++; $display("[TB] FAIL write_done_cycle: got %0d expected 64", dn); end
    checks++; if (b0 !== 1'b1) begin fails++; $display("[TB] FAIL write_busy: got %b expected 1", b0); end
    checks++; if (da !== 1'b0 || ba !== 1'b0) begin fails++; $display("[TB] FAIL write_after: done %b busy %b expected 0 0", da, ba); end
    checks++; if (rd_at !== 16'h0000 || rd_after !== 16'h0000) begin fails++; $display("[TB] FAIL write_rd_hold: got %h/%h expected 0000", rd_at, rd_after); end
  endtask

  task automatic test_read();
    logic [63:0] bits, ios; int dn; logic [15:0] rd_at, rd_after; logic ta_at, b0, da, ba;
    do_frame(1'b1, 5'h1F, 5'h02, 16'h0000, 16'h0141, 1'b0, bits, ios, dn, rd_at, ta_at, b0, da, ba, rd_after);
    checks++; if (bits[63:18] !== EXP_R_HEAD) begin fails++; $display("[TB] FAIL read_bits: got %h expected %h", bits[63:18], EXP_R_HEAD); end
    checks++; if (ios !== EXP_R_IO) begin fails++; $display("[TB] FAIL read_io: got %h expected %h", ios, EXP_R_IO); end
    checks++; if (dn != 64) begin fails++; $display("[TB] FAIL read_done_cycle: got %0d expected 64", dn); end
    checks++; if (rd_at !== 16'h0141) begin fails++; $display("[TB] FAIL read_rd_at_done: got %h expected 0141", rd_at); end
    checks++; if (rd_after !== 16'h0141) begin fails++; $display("[TB] FAIL read_rd_after: got %h expected 0141", rd_after); end
    checks++; if (ta_at !== 1'b0) begin fails++; $display("[TB] FAIL read_ta: got %b expected 0", ta_at); end
  endtask

  task automatic test_ta_error();
    logic [63:0] bits, ios; int dn; logic [15:0] rd_at, rd_after; logic ta_at, b0, da, ba;
    do_frame(1'b1, 5'h03, 5'h01, 16'h0000, 16'hBEEF, 1'b1, bits, ios, dn, rd_at, ta_at, b0, da, ba, rd_after);
    checks++; if (ta_at !== TA_BAD_EXP) begin fails++; $display("[TB] FAIL ta_bad_read: got %b expected %b", ta_at, TA_BAD_EXP); end
    checks++; if (rd_at !== 16'hBEEF) begin fails++; $display("[TB] FAIL ta_bad_rd: got %h expected beef", rd_at); end
    do_frame(1'b0, 5'h03, 5'h01, 16'h1234, 16'h0000, 1'b0, bits, ios, dn, rd_at, ta_at, b0, da, ba, rd_after);
    checks++; if (ta_at !== TA_BAD_EXP) begin fails++; $display("[TB] FAIL ta_after_write: got %b expected %b", ta_at, TA_BAD_EXP); end
    checks++; if (rd_after !== 16'hBEEF) begin fails++; $display("[TB] FAIL write_keeps_rd: got %h expected beef", rd_after); end
    do_frame(1'b1, 5'h1F, 5'h02, 16'h0000, 16'h0141, 1'b0, bits, ios, dn, rd_at, ta_at, b0, da, ba, rd_after);
    checks++; if (ta_at !== 1'b0) begin fails++; $display("[TB] FAIL ta_cleared: got %b expected 0", ta_at); end
    checks++; if (rd_after !== 16'h0141) begin fails++; $display("[TB] FAIL ta_good_rd: got %h expected 0141", rd_after); end
  endtask

  task automatic test_start_ignored();
    int n; int dones; int first;
    @(negedge clk);
    start0 = 1'b1; rw = 1'b0; phy = 5'h03; regad = 5'h04; wr = 16'hA5A5;
    @(posedge clk); #1; start0 = 1'b0;
    n = 0; dones = 0; first = -1;
    while (n < 140) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) start0 = 1'b1;
      if (n == 11) start0 = 1'b0;
      #1;
      if (done0) begin
        dones++;
        if (first < 0) first = n;
      end
    end
    checks++; if (dones != 1) begin fails++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones); end
    checks++; if (first != 64) begin fails++; $display("[TB] FAIL ignore_done_cycle: got %0d expected 64", first); end
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL ignore_busy_end: got %b expected 0", busy0); end
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    logic [63:0] bits, ios; int dn; logic [15:0] rd_at, rd_after; logic ta_at, b0, da, ba;
    @(negedge clk);
    start0 = 1'b1; rw = 1'b1; phy = 5'h1F; regad = 5'h02; rbit = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (50) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    checks++; if (io0 !== 1'b1) begin fails++; $display("[TB] FAIL midrst_io: got %b expected 1", io0); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin fails++; $display("[TB] FAIL midrst_idle: busy %b done %b expected 0 0", busy0, done0); end
    checks++; if (rd0 !== 16'h0000) begin fails++; $display("[TB] FAIL midrst_rd: got %h expected 0000", rd0); end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done0) dones++;
    end
    checks++; if (dones != 0 || busy0 !== 1'b0) begin fails++; $display("[TB] FAIL midrst_no_done: dones %0d busy %b expected 0 0", dones, busy0); end
    do_frame(1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, bits, ios, dn, rd_at, ta_at, b0, da, ba, rd_after);
    checks++; if (bits !== EXP_W1140 || dn != 64) begin fails++; $display("[TB] FAIL midrst_new_frame: got %h/%0d expected %h/64", bits, dn, EXP_W1140); end
  endtask

  task automatic test_back_to_back();
    int dones; int idles; int last; int gap_bad; int first;
    logic ws0, ws1;
    @(negedge clk);
    rw = 1'b0; phy = 5'h0A; regad = 5'h15; wr = 16'h8001; start1 = 1'b1;
    dones = 0; idles = 0; last = -1; gap_bad = 0; first = -1; ws0 = 1'b0; ws1 = 1'b1;
    for (int n = 0; n <= 138; n++) begin
      @(posedge clk); #1;
      if (n == 0) ws0 = w1;
      if (n == 1) ws1 = w1;
      if (busy1 === 1'b0) idles++;
      if (done1) begin
        dones++;
        if (first < 0) first = n;
        if (last >= 0 && (n - last) != 35) gap_bad++;
        last = n;
      end
    end
    @(negedge clk); start1 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (ws0 !== 1'b1 || ws1 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_slots: got %b%b expected 10", ws0, ws1); end
    checks++; if (first != 33) begin fails++; $display("[TB] FAIL b2b_first_done: got %0d expected 33", first); end
    checks++; if (dones != 4) begin fails++; $display("[TB] FAIL b2b_done_count: got %0d expected 4", dones); end
    checks++; if (gap_bad != 0) begin fails++; $display("[TB] FAIL b2b_spacing: got %0d bad gaps expected 0", gap_bad); end
    checks++; if (idles != 3) begin fails++; $display("[TB] FAIL b2b_idle_cycles: got %0d expected 3", idles); end
    checks++; if (busy1 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_stop: got %b expected 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ta_error();
    test_start_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
